// File: rtl/sobel_window_filter_pkg.sv
// Shared types and the RGB444-to-gray helper for the Sobel window filter.
package sobel_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef logic [5:0]        gray_t;
    typedef logic signed [9:0] grad_t;
    typedef logic [8:0]        mag_t;

    // win[row][col]; row 0 is the top of the window, col 2 the newest column
    typedef gray_t [2:0][2:0]  window_t;

    localparam gray_t GRAY_MAX = 6'd60;

    function automatic gray_t rgb_to_gray(input rgb444_t px);
        gray_t sum;
        sum = gray_t'({2'b00, px.r}) + gray_t'({1'b0, px.g, 1'b0}) + gray_t'({2'b00, px.b});
        // Unreachable clamp for legal RGB444; documents the range downstream relies on
        return (sum > GRAY_MAX) ? GRAY_MAX : sum;
    endfunction

endpackage

// File: rtl/sobel_window_filter_if.sv
// Column-in / edge-pixel-out stream between the line buffer, the filter and the frame-store path.
interface sobel_window_filter_if;
    import sobel_pkg::*;

    rgb444_t row0_pixel;
    rgb444_t row1_pixel;
    rgb444_t row2_pixel;
    logic    in_edge;
    logic    in_valid;
    rgb444_t out_pixel;
    logic    out_edge;
    logic    out_valid;

    modport master (
        output row0_pixel, row1_pixel, row2_pixel, in_edge, in_valid,
        input  out_pixel, out_edge, out_valid
    );

    modport slave (
        input  row0_pixel, row1_pixel, row2_pixel, in_edge, in_valid,
        output out_pixel, out_edge, out_valid
    );

endinterface

// File: rtl/sobel_window_filter_kernel.sv
// Combinational 3x3 Sobel kernel: gray window in, signed Gx/Gy out (each within -240..240).
module sobel_kernel
    import sobel_pkg::*;
(
    input  window_t win_i,
    output grad_t   gx_o,
    output grad_t   gy_o
);

    function automatic grad_t sx(input gray_t g);
        return grad_t'({4'b0000, g});
    endfunction

    assign gx_o = (sx(win_i[0][2]) + (sx(win_i[1][2]) <<< 1) + sx(win_i[2][2]))
                - (sx(win_i[0][0]) + (sx(win_i[1][0]) <<< 1) + sx(win_i[2][0]));

    assign gy_o = (sx(win_i[0][0]) + (sx(win_i[0][1]) <<< 1) + sx(win_i[0][2]))
                - (sx(win_i[2][0]) + (sx(win_i[2][1]) <<< 1) + sx(win_i[2][2]));

endmodule

// File: rtl/sobel_window_filter.sv
// 3-stage Sobel edge filter over a sliding 3x3 gray window, one RGB444 edge pixel per column.
// Define SOBEL_THRESHOLD_EN to binarise the magnitude against THRESHOLD instead of grading it.
module sobel_window_filter
    import sobel_pkg::*;
#(
`ifdef SOBEL_THRESHOLD_EN
    parameter int THRESHOLD = 64
`else
    parameter int MAG_SHIFT = 4
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    sobel_window_filter_if.slave  bus
);

    logic [3:1] vld_pipe_q;

    // Stage 1: window and position tracking
    window_t    win_q, win_d;
    logic [1:0] col_cnt_q, col_cnt_d;
    logic [1:0] line_cnt_q, line_cnt_d;
    logic       border_d;
    logic       edge1_q, border1_q;

    // Stage 2: gradients
    grad_t      gx_d, gy_d;
    grad_t      gx_q, gy_q;
    logic       edge2_q, border2_q;

    // Stage 3: magnitude to pixel
    grad_t      abs_gx, abs_gy;
    mag_t       mag;
    rgb444_t    out_pixel_q, out_pixel_d;
    logic       out_edge_q;

    always_comb begin
        col_cnt_d  = col_cnt_q;
        line_cnt_d = line_cnt_q;
        win_d      = win_q;
        if (bus.in_valid) begin
            if (bus.in_edge) begin
                col_cnt_d = 2'd0;
                if (line_cnt_q != 2'd3) line_cnt_d = line_cnt_q + 2'd1;
            end else if (col_cnt_q != 2'd2) begin
                col_cnt_d = col_cnt_q + 2'd1;
            end
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = rgb_to_gray(bus.row0_pixel);
            win_d[1][2] = rgb_to_gray(bus.row1_pixel);
            win_d[2][2] = rgb_to_gray(bus.row2_pixel);
        end
        // Border is judged on the post-update counts so the edge column itself counts as col 0
        border_d = (col_cnt_d < 2'd2) || (line_cnt_d < 2'd3);
    end

    sobel_kernel u_kernel (
        .win_i (win_q),
        .gx_o  (gx_d),
        .gy_o  (gy_d)
    );

    always_comb begin
        abs_gx = gx_q[9] ? -gx_q : gx_q;
        abs_gy = gy_q[9] ? -gy_q : gy_q;
        mag    = mag_t'(abs_gx + abs_gy);
`ifdef SOBEL_THRESHOLD_EN
        out_pixel_d = (!border2_q && (mag >= mag_t'(THRESHOLD))) ? rgb444_t'(12'hFFF)
                                                                   : rgb444_t'(12'h000);
`else
        begin
            mag_t       shifted;
            logic [3:0] inten;
            shifted     = mag >> MAG_SHIFT;
            inten       = (shifted > mag_t'(15)) ? 4'hF : shifted[3:0];
            out_pixel_d = border2_q ? rgb444_t'(12'h000) : rgb444_t'({inten, inten, inten});
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q  <= '0;
            win_q       <= '0;
            col_cnt_q   <= '0;
            line_cnt_q  <= '0;
            edge1_q     <= 1'b0;
            border1_q   <= 1'b0;
            gx_q        <= '0;
            gy_q        <= '0;
            edge2_q     <= 1'b0;
            border2_q   <= 1'b0;
            out_pixel_q <= '0;
            out_edge_q  <= 1'b0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[2:1], bus.in_valid};
            win_q      <= win_d;
            col_cnt_q  <= col_cnt_d;
            line_cnt_q <= line_cnt_d;
            if (bus.in_valid) begin
                edge1_q   <= bus.in_edge;
                border1_q <= border_d;
            end
            if (vld_pipe_q[1]) begin
                gx_q      <= gx_d;
                gy_q      <= gy_d;
                edge2_q   <= edge1_q;
                border2_q <= border1_q;
            end
            if (vld_pipe_q[2]) begin
                out_pixel_q <= out_pixel_d;
                out_edge_q  <= edge2_q;
            end
        end
    end

    assign bus.out_pixel = out_pixel_q;
    assign bus.out_edge  = out_edge_q;
    assign bus.out_valid = vld_pipe_q[3];

endmodule

// File: doc/sobel_window_filter.md
Name: sobel_window_filter

Overview:
- Downstream neighbour of the three-row line buffer. Consumes one vertical column of three RGB444 pixels per valid cycle: row0, row1 and row2 at the same x.
- Builds a 3x3 grayscale window, computes the Sobel |Gx|+|Gy| magnitude and emits one 12-bit RGB444 edge pixel per accepted column.
- The row1 line-start marker travels with its pixel to the output.
- Fixed 3-cycle pipeline with no backpressure; feeds the VGA/frame-store write path.

Parameters:
- MAG_SHIFT, 4, right shift applied to the 9-bit magnitude before saturating to 4 bits.
- THRESHOLD, 64, binarisation level on the unshifted magnitude; used only when SOBEL_THRESHOLD_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- row0_pixel  in  12  newest-row pixel, {R[11:8],G[7:4],B[3:0]}.
- row1_pixel  in  12  centre-row pixel.
- row2_pixel  in  12  oldest-row pixel.
- in_edge  in  1  row1 pixel is the first pixel of a line.
- in_valid  in  1  column is valid this cycle.
- out_pixel  out  12  edge pixel; R=G=B=4-bit intensity.
- out_edge  out  1  line-start marker aligned with out_pixel.
- out_valid  out  1  out_pixel and out_edge are valid this cycle.

Behaviour:
- Reset, synchronous, active-high:
  - out_pixel=0, out_edge=0, out_valid=0.
  - Window registers, stage registers, stage valids, col_cnt and line_cnt all cleared.
  - Reset asserted mid-stream discards every in-flight column; no output valid for 3 cycles after reset deasserts.
- Gray conversion: gray = R + 2G + B, 6-bit unsigned, range 0..60.
- Stage 1, on in_valid only:
  - Shift the 3x3 gray window left one column: col0<=col1, col1<=col2, col2<=new gray column.
  - Update counters (below).
  - Register in_edge and a border flag.
  - v1 <= in_valid every cycle.
- Stage 2, every cycle, using signed 10-bit arithmetic:
  - Gx = (p02 + 2p12 + p22) - (p00 + 2p10 + p20).
  - Gy = (p00 + 2p01 + p02) - (p20 + 2p21 + p22).
  - Row 0 is the top row of the window. Each result is in the range -240..240.
  - v2 <= v1.
- Stage 3: mag = |Gx| + |Gy|, 9-bit unsigned, 0..480; v3 <= v2.
  - Intensity I = min(mag >> MAG_SHIFT, 15).
  - out_pixel <= {I,I,I}, or 0 when the border flag is set.
  - out_edge <= staged edge; out_valid <= v2.
- Register hold: stage registers and out_pixel/out_edge load only when their stage valid is high and hold otherwise. out_valid itself is updated every cycle.
- Latency: exactly 3 clocks from an in_valid cycle to its out_valid. Gaps in in_valid reproduce as identical gaps in out_valid.
- col_cnt (2 bits, saturates at 2):
  - in_valid & in_edge: col_cnt <= 0.
  - Otherwise, on in_valid: increment.
- line_cnt (2 bits, saturates at 3): increments on in_valid & in_edge.
- Border flag, evaluated on the incoming column (value after update): set when col_cnt < 2 or line_cnt < 3.
  - First two columns of every line output 0.
  - All pixels of the first two lines after reset output 0.
  - Pixels before the first in_edge output 0.
- in_edge while in_valid=0 is ignored.
- Back-to-back in_edge columns: col_cnt stays 0 and both outputs are border.
- No overflow is possible given the widths above. Magnitude saturation happens only in the shift/min step.

Optional Feature:
- SOBEL_THRESHOLD_EN defined: stage 3 outputs out_pixel = 12'hFFF when mag >= THRESHOLD and not border, else 12'h000. MAG_SHIFT is unused. Latency is unchanged.
- Undefined: graded intensity as described in Behaviour.

Decomposition:
- Package sobel_pkg:
  - typedef rgb444_t (12-bit packed R/G/B struct).
  - gray_t (6-bit), grad_t (signed 10-bit), mag_t (9-bit).
  - localparam GRAY_MAX=60.
- One sub-module, sobel_kernel: purely combinational 3x3 gray_t to Gx/Gy, instantiated in stage 2.
- Gray conversion is a package function rgb_to_gray().

Test Plan:
- Reset: hold rst for 2 cycles mid-stream with in_valid=1 -> out_valid=0 and out_pixel=0 for the reset cycles plus the next 3 cycles.
- Uniform 12'hFFF frame: 4 lines of 8 columns, in_edge on column 0 -> lines 1-2 all 0 (border); lines 3-4, columns 0-1 give 0 and columns 2+ give 0 (mag=0).
- Vertical step, after the border lines: columns 0-3 = 12'h000, columns 4-7 = 12'hFFF. Window 0,0,60 gives Gx=240, Gy=0, mag=240 -> out_pixel=12'hFFF (240>>4=15) exactly 3 cycles after the column-4 input.
- Horizontal step, row2 dark and rows 0,1 bright (12'hFFF): Gy=240 -> out_pixel=12'hFFF. With row0 bright, rows 1,2 dark: window gray 60/0/0 gives Gy=240 -> 12'hFFF.
- Gapped input: in_valid pattern 1,0,0,1,1 -> out_valid pattern 1,0,0,1,1 shifted 3 cycles; out_pixel holds during gaps; out_edge aligned with the column that carried in_edge.
- With SOBEL_THRESHOLD_EN: mag=63 -> 12'h000; mag=64 -> 12'hFFF; border pixels stay 12'h000.
